// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS fetch/hazard logic.
//   pc_t        - 16-bit word address
//   reg_idx_t   - 5-bit register index
//   hz_state_e  - hazard controller state (RUN / FLUSH)
//   NO_LOAD     - PC load value meaning "do not load"
package mips_pkg;

  typedef logic [15:0] pc_t;
  typedef logic [4:0]  reg_idx_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} hz_state_e;

  localparam pc_t NO_LOAD = 16'd0;

  // A load in EX whose destination feeds the instruction in ID.
  // r0 is never a real dependency.
  function automatic logic load_use_hit(
    input logic     memread,
    input reg_idx_t ex_rt,
    input logic     id_valid,
    input reg_idx_t id_rs,
    input reg_idx_t id_rt,
    input logic     uses_rt
  );
    return memread && (ex_rt != '0) && id_valid &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/md_timer.sv
// md_timer: loadable down-counter tracking multiply/divide unit occupancy.
//   clk_i   in  clock
//   rst     in  synchronous active-high reset (count -> 0)
//   load_i  in  (re)load the counter with LAT; wins over the decrement
//   busy_o  out count != 0
module md_timer #(
  parameter int W   = 4,
  parameter int LAT = 4
) (
  input  logic clk_i,
  input  logic rst,
  input  logic load_i,
  output logic busy_o
);

  logic [W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst)                count <= '0;
    else if (load_i)        count <= W'(LAT);
    else if (count != '0)   count <= count - 1'b1;
  end

  assign busy_o = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: fetch-sequencing and hazard controller.
// Each cycle picks one of: load a branch target, hold the PC, or advance.
// Outputs are combinational from current inputs and registered state.
//   clk_i, rst                  clock, synchronous active-high reset
//   id_*                        ID-stage operand info
//   ex_memread_i, ex_rt_i       EX load and its destination
//   md_start_i                  EX launches mult/div
//   br_taken_i, br_target_i     EX resolved taken branch and target
//   cnt_o                       PC load value (0 = no load)
//   haz_o                       1 = advance PC, 0 = hold
//   flush_o, bubble_o           squash IF/ID, insert NOP into ID/EX
//   stall_cnt_o                 saturating stall-cycle count
//   err_o                       sticky: taken branch to address 0 seen
import mips_pkg::*;

module hazard_ctrl #(
  parameter int FLUSH_CYC = 1,
  parameter int MD_LAT    = 4
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_uses_rt_i,
  input  logic        id_hilo_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rt_i,
  input  logic        md_start_i,
  input  logic        br_taken_i,
  input  logic [15:0] br_target_i,
  output logic [15:0] cnt_o,
  output logic        haz_o,
  output logic        flush_o,
  output logic        bubble_o,
  output logic [15:0] stall_cnt_o,
  output logic        err_o
);

  // The branch cycle itself is the first flush cycle, so FLUSH covers
  // the remaining FLUSH_CYC-1 cycles.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       md_busy;
  logic       stall_inc;
  logic       err_set;

  md_timer #(.W(4), .LAT(MD_LAT)) u_md_timer (
    .clk_i  (clk_i),
    .rst    (rst),
    .load_i (md_start_i),
    .busy_o (md_busy)
  );

  always_comb begin
    cnt_o     = NO_LOAD;
    haz_o     = 1'b1;
    flush_o   = 1'b0;
    bubble_o  = 1'b0;
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    stall_inc = 1'b0;
    err_set   = 1'b0;
    if (rst) begin
      haz_o   = 1'b0;
      state_d = RUN;
      fcnt_d  = '0;
    end else if (br_taken_i) begin
      // A target of 0 aliases "no load"; it still drives 0 but is flagged.
      cnt_o    = br_target_i;
      haz_o    = 1'b0;
      flush_o  = 1'b1;
      bubble_o = 1'b1;
      err_set  = (br_target_i == NO_LOAD);
      if (FLUSH_INIT != '0) begin
        state_d = FLUSH;
        fcnt_d  = FLUSH_INIT;
      end else begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    end else if (state_q == FLUSH) begin
      // ID content is being squashed, so no hazard checks here.
      flush_o = 1'b1;
      if (fcnt_q <= 3'd1) begin
        state_d = RUN;
        fcnt_d  = '0;
      end else begin
        fcnt_d  = fcnt_q - 3'd1;
      end
    end else if (md_busy && id_valid_i && id_hilo_i) begin
      haz_o     = 1'b0;
      bubble_o  = 1'b1;
      stall_inc = 1'b1;
    end else if (load_use_hit(ex_memread_i, ex_rt_i, id_valid_i,
                              id_rs_i, id_rt_i, id_uses_rt_i)) begin
      haz_o     = 1'b0;
      bubble_o  = 1'b1;
      stall_inc = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      stall_cnt_o <= '0;
      err_o       <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (stall_inc && (stall_cnt_o != 16'hFFFF))
        stall_cnt_o <= stall_cnt_o + 16'd1;
      if (err_set)
        err_o <= 1'b1;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and fetch-sequencing controller for the MIPS core; drives the program counter's load value and advance-enable. Each cycle it decides whether fetch advances by one, holds (stall), or loads a branch target. It also generates the IF/ID flush and ID/EX bubble controls and keeps a saturating stall statistic.

## Interface
- FLUSH_CYC, 1: cycles of `flush_o` after a taken branch (1..7).
- MD_LAT, 4: busy cycles of the multiply/divide unit after `md_start_i` (1..15).
- clk_i  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_valid_i  in  1  ID stage holds a real instruction.
- id_rs_i  in  5  ID source register rs.
- id_rt_i  in  5  ID source register rt.
- id_uses_rt_i  in  1  ID instruction reads rt.
- id_hilo_i  in  1  ID instruction is mfhi/mflo/mult/div (needs the MD unit idle).
- ex_memread_i  in  1  EX instruction is a load.
- ex_rt_i  in  5  EX load destination register.
- md_start_i  in  1  EX launches a mult/div this cycle.
- br_taken_i  in  1  EX resolved a taken branch/jump.
- br_target_i  in  16  branch target word address.
- cnt_o  out  16  PC load value; 0 = no load.
- haz_o  out  1  1 = PC advances by one, 0 = PC holds.
- flush_o  out  1  squash IF/ID.
- bubble_o  out  1  insert NOP into ID/EX.
- stall_cnt_o  out  16  saturating count of stall cycles.
- err_o  out  1  sticky: taken branch with target 0 seen.

## Operation
- States: RUN, FLUSH. Registered: state, flush down-counter (3 bit), MD busy down-counter (4 bit), stall_cnt_o, err_o.
- Decision priority each cycle: reset > branch > MD hazard > load-use > advance.
- Branch: br_taken_i=1 -> cnt_o=br_target_i, haz_o=0, flush_o=1, bubble_o=1; next state FLUSH with counter FLUSH_CYC-1 (stays RUN if FLUSH_CYC=1). Branch in FLUSH restarts the flush count.
- Target 0 cannot be expressed (0 = no load): cnt_o drives 0, err_o sets and holds until reset.
- FLUSH: flush_o=1, haz_o=1, cnt_o=0; ID treated invalid (no hazard checks); counter decrements, exit to RUN after reaching 0.
- MD hazard: MD counter nonzero and id_valid_i and id_hilo_i -> haz_o=0, bubble_o=1.
- md_start_i loads MD counter with MD_LAT (overrides decrement, also when already busy); otherwise decrement while nonzero.
- Load-use: ex_memread_i and ex_rt_i!=0 and id_valid_i and (ex_rt_i==id_rs_i or (id_uses_rt_i and ex_rt_i==id_rt_i)) -> haz_o=0, bubble_o=1.
- Otherwise haz_o=1, cnt_o=0, flush_o=0, bubble_o=0.
- stall_cnt_o increments on each cycle with haz_o=0 and no branch; saturates at 16'hFFFF.

## Timing
- Outputs combinational from current inputs and registered state: zero-cycle decision, visible to the PC the same edge.
- State/counters update on the clock edge after the triggering input.
- rst=1: cnt_o=0, haz_o=0, flush_o=0, bubble_o=0 combinationally; next edge state=RUN, counters=0, stall_cnt_o=0, err_o=0. Reset mid-FLUSH or mid-MD-busy aborts both.
- Load-use stall lasts exactly one cycle (bubble clears ex_memread_i).
- MD stall ends the cycle after the MD counter reaches 0.
- Simultaneous branch + any hazard: branch wins, no stall counted.

## Structure
- mips_pkg: pc_t (logic [15:0]), reg_idx_t (logic [4:0]), hz_state_e {RUN, FLUSH}, NO_LOAD = 16'd0.
- One sub-module: md_timer (loadable down-counter, busy_o = count!=0).

## Test plan
- Reset: rst high 2 cycles -> cnt_o=0, haz_o=0, stall_cnt_o=0; release -> haz_o=1.
- Load-use: ex_memread_i=1, ex_rt_i=5, id_rs_i=5, id_valid_i=1 -> one cycle haz_o=0, bubble_o=1, stall_cnt_o=1; ex_rt_i=0 -> no stall.
- Branch: br_taken_i=1, br_target_i=16'h0040 with FLUSH_CYC=3 -> cnt_o=0x0040 that cycle, flush_o high 3 cycles, then RUN.
- MD: md_start_i at t, id_hilo_i held from t+1 with MD_LAT=4 -> haz_o=0 for 4 cycles, then 1; re-start at t+2 extends to t+6.
- Branch + load-use same cycle -> cnt_o=target, no stall counted; target 0 -> cnt_o=0, err_o=1 sticky.
- Saturation: force 70000 stall cycles -> stall_cnt_o holds 16'hFFFF.
